// File: rtl/hilo_md_ctrl.sv
// Iterative HI/LO multiply/divide controller: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fix-up at the end.
module hilo_md_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_op_div,
  input  logic             i_is_sign,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  input  logic             i_cancel,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic             r_op_div, r_neg_q, r_neg_r, r_bz;
  logic [WIDTH-1:0] r_m, r_q, r_a_raw;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_res_hi, r_res_lo, r_hi, r_lo;
  logic             r_dz;

  logic             w_go, w_last, w_sa, w_sb, w_ge;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_q_nxt, w_fix_hi, w_fix_lo;
  logic [WIDTH:0]   w_sum, w_rs, w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;

  assign w_go    = i_start & ~i_cancel;
  assign w_last  = (r_cnt == CW'(WIDTH-1));
  assign w_sa    = i_is_sign & i_srca[WIDTH-1];
  assign w_sb    = i_is_sign & i_srcb[WIDTH-1];
  assign w_abs_a = w_sa ? -i_srca : i_srca;
  assign w_abs_b = w_sb ? -i_srcb : i_srcb;

  // One iteration: r_m is the multiplicand (mult) or divisor (div); r_q holds
  // the multiplier / dividend bits being consumed and the result bits produced.
  always_comb begin
    w_sum = {1'b0, r_acc[WIDTH-1:0]} + (r_q[0] ? {1'b0, r_m} : '0);
    w_rs  = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    w_ge  = (w_rs >= {1'b0, r_m});
    if (r_op_div) begin
      w_acc_nxt = w_ge ? (w_rs - {1'b0, r_m}) : w_rs;
      w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
    end else begin
      w_acc_nxt = {1'b0, w_sum[WIDTH:1]};
      w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_prod = {w_acc_nxt[WIDTH-1:0], w_q_nxt};
    if (!r_op_div) begin
      {w_fix_hi, w_fix_lo} = r_neg_q ? -w_prod : w_prod;
    end else if (r_bz) begin
      w_fix_hi = r_a_raw;
      w_fix_lo = '1;
    end else begin
      w_fix_lo = r_neg_q ? -w_q_nxt : w_q_nxt;
      w_fix_hi = r_neg_r ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_RUN;
      S_RUN:   if (i_cancel) w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_stall = 1'b0;
    o_done  = 1'b0;
    o_busy  = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  o_stall = w_go;
      S_RUN:   o_stall = 1'b1;
      S_DONE:  o_done  = ~i_cancel;
      default: ;
    endcase
  end

  // The result only becomes architectural once DONE completes uncancelled.
  assign o_hi       = o_done ? r_res_hi : r_hi;
  assign o_lo       = o_done ? r_res_lo : r_lo;
  assign o_div_zero = o_done ? r_bz     : r_dz;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt    <= '0;
      r_op_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bz     <= 1'b0;
      r_m      <= '0;
      r_q      <= '0;
      r_a_raw  <= '0;
      r_acc    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_go) begin
          r_cnt    <= '0;
          r_op_div <= i_op_div;
          r_neg_q  <= w_sa ^ w_sb;
          r_neg_r  <= w_sa;
          r_bz     <= i_op_div & (i_srcb == '0);
          r_m      <= i_op_div ? w_abs_b : w_abs_a;
          r_q      <= i_op_div ? w_abs_a : w_abs_b;
          r_a_raw  <= i_srca;
          r_acc    <= '0;
        end
        S_RUN: if (!i_cancel) begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          if (w_last) begin
            r_res_hi <= w_fix_hi;
            r_res_lo <= w_fix_lo;
          end
        end
        S_DONE: if (!i_cancel) begin
          r_hi <= r_res_hi;
          r_lo <= r_res_lo;
          r_dz <= r_bz;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Self-checking bench for hilo_md_ctrl: directed vector table, randomized ops
// against an arithmetic reference model, and cancel/reset/held-start sequences.
module tb_hilo_md_ctrl;
  localparam int W = 32;

  logic         i_clk = 1'b0, i_rst = 1'b0;
  logic         i_start = 1'b0, i_op_div = 1'b0, i_is_sign = 1'b0, i_cancel = 1'b0;
  logic [W-1:0] i_srca = '0, i_srcb = '0;
  logic         o_stall, o_busy, o_done, o_div_zero;
  logic [W-1:0] o_hi, o_lo;

  hilo_md_ctrl #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op_div(i_op_div),
    .i_is_sign(i_is_sign), .i_srca(i_srca), .i_srcb(i_srcb), .i_cancel(i_cancel),
    .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_fail = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;
  logic         last_dz = 1'b0;

  typedef struct {
    string nm; bit d; bit s; logic [W-1:0] a, b, hi, lo; bit dz;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic void model(input bit d, input bit s, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] h,
                                output logic [W-1:0] l, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    dz = 1'b0;
    if (!d) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      h = a; l = '1; dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = 64'(q); l = p[31:0];
      p = 64'(r); h = p[31:0];
    end
  endfunction

  // Issues one request; start held for `hold` cycles, cancel pulsed at cycle ck.
  task automatic run_op(input bit d, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input int ck, output int st, output int dn,
                        output int dat, output logic [W-1:0] h, output logic [W-1:0] l,
                        output logic dz, output logic act_after);
    st = 0; dn = 0; dat = -1; h = '0; l = '0; dz = 1'b0; act_after = 1'b1;
    @(negedge i_clk);
    i_op_div = d; i_is_sign = s; i_srca = a; i_srcb = b; i_start = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      i_cancel = (k == ck);
      #1;
      if (o_stall) st++;
      if (o_done) begin dn++; dat = k; h = o_hi; l = o_lo; dz = o_div_zero; end
      if (ck >= 0 && k == ck + 1) act_after = o_busy | o_stall;
      @(negedge i_clk);
      if (k + 1 >= hold) i_start = 1'b0;
    end
    i_cancel = 1'b0;
  endtask

  task automatic full_op(input string nm, input bit d, input bit s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic edz, input int hold);
    int st, dn, dat;
    logic [W-1:0] h, l;
    logic dz, aa;
    run_op(d, s, a, b, hold, -1, st, dn, dat, h, l, dz, aa);
    chk({nm, ".stall_cycles"}, 64'(st), 64'(W + 1));
    chk({nm, ".done_count"}, 64'(dn), 64'd1);
    chk({nm, ".done_cycle"}, 64'(dat), 64'(W + 1));
    chk({nm, ".result"}, {h, l}, {eh, el});
    chk({nm, ".div_zero"}, 64'(dz), 64'(edz));
    #1;
    chk({nm, ".hold"}, {o_hi, o_lo}, {eh, el});
    last_hi = eh; last_lo = el; last_dz = edz;
  endtask

  initial begin
    int st, dn, dat;
    logic [W-1:0] h, l, eh, el;
    logic dz, edz, aa;
    bit d, s;
    logic [W-1:0] a, b;

    tv[0] = '{"umul_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tv[1] = '{"smul_m3x7", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tv[2] = '{"sdiv_m7d2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tv[3] = '{"udiv_100d7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    tv[4] = '{"div_zero", 1'b1, 1'b1, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    tv[5] = '{"div_after_zero", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    tv[6] = '{"sdiv_min_m1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};

    repeat (2) @(negedge i_clk);
    chk("reset_state", {o_stall, o_busy, o_done, o_div_zero, o_hi, o_lo}, '0);
    i_rst = 1'b1;

    foreach (tv[i]) full_op(tv[i].nm, tv[i].d, tv[i].s, tv[i].a, tv[i].b,
                            tv[i].hi, tv[i].lo, tv[i].dz, 1);

    for (int n = 0; n < 40; n++) begin
      d = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = $urandom_range(1, 9);
        2: a = 32'h80000000;
        3: b = '1;
        default: ;
      endcase
      model(d, s, a, b, eh, el, edz);
      full_op($sformatf("rand%0d", n), d, s, a, b, eh, el, edz, 1);
    end

    // cancel at RUN cycle 10 (cycle 11 after start)
    run_op(1'b1, 1'b0, 32'd1000, 32'd3, 1, 11, st, dn, dat, h, l, dz, aa);
    chk("cancel_run.idle_next", 64'(aa), 64'd0);
    chk("cancel_run.no_done", 64'(dn), 64'd0);
    chk("cancel_run.stall_cycles", 64'(st), 64'd12);
    chk("cancel_run.hold", {o_div_zero, o_hi, o_lo}, {last_dz, last_hi, last_lo});

    // cancel during DONE
    run_op(1'b0, 1'b0, 32'd5, 32'd6, 1, W + 1, st, dn, dat, h, l, dz, aa);
    chk("cancel_done.no_done", 64'(dn), 64'd0);
    chk("cancel_done.idle_next", 64'(aa), 64'd0);
    chk("cancel_done.hold", {o_hi, o_lo}, {last_hi, last_lo});

    // start & cancel together in IDLE
    run_op(1'b0, 1'b0, 32'd5, 32'd6, 1, 0, st, dn, dat, h, l, dz, aa);
    chk("start_cancel.stall", 64'(st), 64'd0);
    chk("start_cancel.busy_next", 64'(aa), 64'd0);
    chk("start_cancel.no_done", 64'(dn), 64'd0);

    // start held through DONE: only one operation
    full_op("held_start", 1'b0, 1'b1, 32'hFFFFFFF0, 32'h00000010,
            32'hFFFFFFFF, 32'hFFFFFF00, 1'b0, W + 2);
    #1;
    chk("held_start.idle_after", {o_busy, o_stall}, 64'd0);

    // reset at RUN cycle 5, after a div-by-zero left nonzero state
    full_op("pre_rst_div0", 1'b1, 1'b0, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b1, 1);
    @(negedge i_clk);
    i_op_div = 1'b0; i_is_sign = 1'b0; i_srca = 32'd9; i_srcb = 32'd9; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_mid", {o_stall, o_busy, o_done, o_div_zero, o_hi, o_lo}, '0);
    @(negedge i_clk);
    i_rst = 1'b1;
    full_op("post_rst", 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
